uart_rx: RTL
============

# uart_rx

Serial UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It recovers bytes from the asynchronous `i_rx` line and presents each byte on a parallel output with a one-cycle valid strobe. It pairs with the team's UART transmitter and uses the same `BAUD` divisor convention from `baudgen.vh`, so both ends can be instantiated with one baud setting. It sits between the board pin and the byte-level consumer logic (FIFO or command parser).

## Interface
- `BAUD`, default `` `B115200 ``: clock cycles per bit period. Integer, minimum 4.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rstn`  input  1  reset; one clock; reset is asynchronous and active-low.
- `i_rx`  input  1  serial line; idles high; asynchronous to `clk`.
- `o_data`  output  8  last correctly framed byte; holds its value until the next good frame.
- `o_valid`  output  1  one-cycle pulse; `o_data` is new this cycle.
- `o_frame_err`  output  1  one-cycle pulse; the stop bit was sampled low.
- `o_busy`  output  1  high while a frame is in progress (state is not IDLE).

## Operation
- `i_rx` passes through a 2-flop synchronizer, whose reset value is 1. A third flop holds the previous synced value for edge detection. All further logic uses the synced signal `rx_s`.
- A bit counter `bitcnt` is 3 bits wide. A baud counter `cnt` is sized to hold BAUD-1.
- The shift register fills MSB-in with a right shift, so after 8 shifts bit 0 of the register is the first received bit.
- States are one-hot: IDLE, START, DATA, STOP.
- **IDLE:** `o_busy`=0. A falling edge on `rx_s` (previous 1, current 0) moves to START and clears `cnt`. A line held low without a 1→0 edge does not start a frame.
- **START:** count to `BAUD/2` (floor), then sample `rx_s`.
  - If the sample is 1, the start was a glitch: return to IDLE with no outputs.
  - If the sample is 0, go to DATA with `cnt`=0 and `bitcnt`=0.
- **DATA:** every BAUD cycles, sample `rx_s` into the shift register and increment `bitcnt`. After the 8th sample (`bitcnt` wraps 7→0), go to STOP.
- **STOP:** after BAUD cycles, sample `rx_s`.
  - If the sample is 1: load `o_data` from the shift register and pulse `o_valid`.
  - If the sample is 0: pulse `o_frame_err` and leave `o_data` unchanged.
  - Either way, go to IDLE at mid-stop-bit. This allows a back-to-back frame whose start edge comes half a bit later.
- `o_valid` and `o_frame_err` are never high in the same cycle.
- Each pulse lasts exactly one cycle, regardless of what the consumer does. There is no backpressure.
- `rstn` low at any time, including mid-frame:
  - state goes to IDLE;
  - counters and the shift register clear;
  - all outputs go to 0;
  - the synchronizer goes to 1.
- After `rstn` deasserts, the first frame is recognized only on a new falling edge.

## Timing
- Reset values: `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0.
- Let t be the cycle in which the edge detector sees the falling edge. This is 2–3 clk cycles after `i_rx` falls.
  - Start sample: cycle t + BAUD/2.
  - Data bit k (k = 0..7): cycle t + BAUD/2 + (k+1)·BAUD.
  - Stop sample: cycle t + BAUD/2 + 9·BAUD.
  - `o_valid` or `o_frame_err`, together with the new `o_data`, is registered high in the cycle after the stop sample. `o_busy` falls in that same cycle.
- Sampling error tolerance: ±1 cycle of edge-detect jitter plus the BAUD/2 floor. This is adequate for baud mismatch of ±2% or less at BAUD ≥ 16.
- Minimum gap between frames: 0 idle cycles beyond the stop bit. A start edge arriving any time after mid-stop-bit is accepted.

## Test plan
The bench uses BAUD=16, and the driver holds each bit for exactly 16 clk cycles.
- **Single frame 0x55 with a good stop bit:** one `o_valid` pulse with `o_data`=8'h55, `o_frame_err`=0, and `o_busy` high for the whole frame.
- **Back-to-back 0xA3 then 0x0F, no idle gap:** two `o_valid` pulses 160 cycles apart, with `o_data`=8'hA3 then 8'h0F.
- **Glitch on `i_rx` low for 4 cycles from idle:** the receiver returns to IDLE at the start sample, with no `o_valid` and no `o_frame_err`. `o_busy` is high for at most 8+3 cycles.
- **Frame 0x3C with the stop bit driven low, sent after a good 0x81:** one `o_frame_err` pulse, no `o_valid`, and `o_data` stays at 8'h81.
- **`rstn` pulsed low during data bit 4 of 0xFF, then a fresh frame 0x12:** all outputs are 0 immediately during reset, no output for the aborted frame, then `o_valid` with `o_data`=8'h12.
- **`i_rx` held low through and after reset release:** no frame starts until `i_rx` rises and then falls.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-side outputs of the 8N1 receiver: received byte, valid/frame-error strobes, busy.
// The receiver drives through the master modport; the consumer reads through the slave modport.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (output o_data, output o_valid, output o_frame_err, output o_busy);
  modport slave  (input  o_data, input  o_valid, input  o_frame_err, input  o_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: o_valid/o_frame_err pulse one cycle after the mid-stop-bit sample
// (about BAUD/2 + 9*BAUD + 4 cycles after i_rx falls); no backpressure, every pulse is one cycle.
module uart_rx #(
  parameter int BAUD = 104  // clock cycles per bit
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_rx,
  uart_rx_if.master rx_out
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            prev_q, prev_d;
  logic [1:0]      settle_q, settle_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;
  logic            fall;

  assign rx_s = sync_q[1];
  // The synchronizer's reset value is not a real line sample, so edges are only
  // trusted once three post-reset samples have flushed through; a line held low
  // across reset therefore cannot fake a start edge.
  assign fall = (settle_q == 2'd3) && prev_q && !rx_s;

  always_comb begin
    sync_d   = {sync_q[0], i_rx};
    prev_d   = rx_s;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          shreg_d  = {rx_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a start edge right at the stop-bit end is caught.
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      settle_q <= 2'd0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_out.o_data      = data_q;
  assign rx_out.o_valid     = valid_q;
  assign rx_out.o_frame_err = ferr_q;
  assign rx_out.o_busy      = (state_q != IDLE);

endmodule
